// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with next-address selection, a valid/ready
// fetch handshake to instruction memory, and misaligned-target parking.
`ifndef PC_MUX_ALU_OUT
`define PC_MUX_ALU_OUT 2'b01
`endif
`ifndef PC_MUX_PC_ADDER
`define PC_MUX_PC_ADDER 2'b10
`endif

module pc_fetch_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned     ALIGN_BITS   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [1:0]      pc_sel,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] pc_adder_result,
   input  logic            trap_req,
   input  logic            mret_req,
   input  logic [XLEN-1:0] epc,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_addr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next,
   output logic            misalign_err,
   output logic [XLEN-1:0] misalign_addr
);

   localparam logic [XLEN-1:0] INC  = {{(XLEN-1){1'b0}}, 1'b1} << ALIGN_BITS;
   localparam logic [XLEN-1:0] MASK = INC - {{(XLEN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pending_q, pending_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] maddr_q, maddr_d;
   logic [XLEN-1:0] target;
   logic            misaligned;

   assign pc_next       = pc_q + INC;
   assign pc            = pc_q;
   assign fetch_addr    = pc_q;
   assign fetch_valid   = ((state_q == RUN) && en) || (state_q == HOLD);
   assign misalign_err  = err_q;
   assign misalign_addr = maddr_q;

   // Redirect priority: trap, mret, JALR (bit 0 cleared), branch/JAL, sequential.
   always_comb begin
      target = pc_next;
      if (trap_req)                        target = TRAP_VECTOR;
      else if (mret_req)                   target = epc;
      else if (pc_sel == `PC_MUX_ALU_OUT)  target = {alu_result[XLEN-1:1], 1'b0};
      else if (pc_sel == `PC_MUX_PC_ADDER) target = pc_adder_result;
      // Trap vector is aligned by construction, so traps are never flagged.
      misaligned = !trap_req && ((target & MASK) != '0);
   end

   // Next-state logic for the fetch FSM and its datapath registers.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pending_d = pending_q;
      err_d     = err_q;
      maddr_d   = maddr_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (en) begin
               if (misaligned) begin
                  err_d   = 1'b1;
                  maddr_d = target;
                  state_d = HALT;
               end else if (fetch_ready) begin
                  pc_d = target;
               end else begin
                  pending_d = target;
                  state_d   = HOLD;
               end
            end else if (trap_req) begin
               // Traps redirect even while the pipeline is stalled.
               pc_d = TRAP_VECTOR;
            end
         end
         HOLD: begin
            // A trap arriving while stalled replaces the frozen redirect.
            if (fetch_ready) begin
               pc_d    = trap_req ? TRAP_VECTOR : pending_q;
               state_d = RUN;
            end else if (trap_req) begin
               pending_d = TRAP_VECTOR;
            end
         end
         HALT: begin
            if (trap_req) begin
               pc_d    = TRAP_VECTOR;
               err_d   = 1'b0;
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State and datapath registers; reset abandons any pending redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BOOT;
         pc_q      <= RESET_VECTOR;
         pending_q <= '0;
         err_q     <= 1'b0;
         maddr_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         maddr_q   <= maddr_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed test of pc_fetch_unit with hand-computed expectations.
`ifndef PC_MUX_ALU_OUT
`define PC_MUX_ALU_OUT 2'b01
`endif
`ifndef PC_MUX_PC_ADDER
`define PC_MUX_PC_ADDER 2'b10
`endif

module tb_pc_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n, en, trap_req, mret_req, fetch_ready;
   logic [1:0]  pc_sel;
   logic [31:0] alu_result, pc_adder_result, epc;
   logic        fetch_valid, misalign_err;
   logic [31:0] fetch_addr, pc, pc_next, misalign_addr;
   int          n_assert = 0;
   int          n_fail   = 0;

   pc_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pc_sel(pc_sel),
      .alu_result(alu_result), .pc_adder_result(pc_adder_result),
      .trap_req(trap_req), .mret_req(mret_req), .epc(epc),
      .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
      .fetch_addr(fetch_addr), .pc(pc), .pc_next(pc_next),
      .misalign_err(misalign_err), .misalign_addr(misalign_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; pc_sel = 2'b00; trap_req = 1'b0; mret_req = 1'b0;
      alu_result = '0; pc_adder_result = '0; epc = '0; fetch_ready = 1'b0;
      #12;
      chk("rst_pc", pc, 32'h0);
      chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
      chk("rst_err", {31'b0, misalign_err}, 32'h0);
      chk("rst_maddr", misalign_addr, 32'h0);
      rst_n = 1'b1; en = 1'b1; fetch_ready = 1'b1;
      #1;
      chk("boot_fv", {31'b0, fetch_valid}, 32'h0);
      tick();  // BOOT -> RUN
      chk("run_fv", {31'b0, fetch_valid}, 32'h1);
      chk("seq0", fetch_addr, 32'h0);
      chk("pcnext0", pc_next, 32'h4);
      tick(); chk("seq1", fetch_addr, 32'h4);
      tick(); chk("seq2", fetch_addr, 32'h8);
      tick(); chk("seq3", fetch_addr, 32'hC);
      chk("pcnext3", pc_next, 32'h10);

      // Stalled branch: address frozen at 0xC for three cycles.
      pc_sel = `PC_MUX_PC_ADDER; pc_adder_result = 32'h40; fetch_ready = 1'b0;
      tick(); chk("hold0", fetch_addr, 32'hC); chk("hold0_fv", {31'b0, fetch_valid}, 32'h1);
      pc_sel = 2'b00; en = 1'b0;  // ignored while holding
      tick(); chk("hold1", fetch_addr, 32'hC); chk("hold1_fv", {31'b0, fetch_valid}, 32'h1);
      tick(); chk("hold2", fetch_addr, 32'hC);
      fetch_ready = 1'b1; en = 1'b1;
      tick(); chk("hold_done", fetch_addr, 32'h40);

      // JALR to 0x103 -> 0x102, misaligned -> HALT.
      pc_sel = `PC_MUX_ALU_OUT; alu_result = 32'h103;
      tick();
      chk("mis_err", {31'b0, misalign_err}, 32'h1);
      chk("mis_addr", misalign_addr, 32'h102);
      chk("mis_fv", {31'b0, fetch_valid}, 32'h0);
      chk("mis_pc", pc, 32'h40);
      pc_sel = 2'b00;
      tick(); chk("halt_pc", pc, 32'h40);
      trap_req = 1'b1;
      tick();
      chk("halt_trap_pc", pc, 32'h100);
      chk("halt_trap_err", {31'b0, misalign_err}, 32'h0);
      chk("halt_keep_maddr", misalign_addr, 32'h102);
      trap_req = 1'b0;
      tick(); chk("seq_104", pc, 32'h104);

      // trap beats mret, then mret alone.
      trap_req = 1'b1; mret_req = 1'b1; epc = 32'h80;
      tick(); chk("trap_vs_mret", pc, 32'h100);
      trap_req = 1'b0;
      tick(); chk("mret", pc, 32'h80);
      mret_req = 1'b0;

      // Trap with simultaneous misaligned branch target: no error.
      pc_sel = `PC_MUX_PC_ADDER; pc_adder_result = 32'h42; trap_req = 1'b1;
      tick(); chk("trap_mis_pc", pc, 32'h100);
      chk("trap_mis_err", {31'b0, misalign_err}, 32'h0);
      trap_req = 1'b0;

      // Wrap-around at top of address space.
      pc_adder_result = 32'hFFFF_FFFC;
      tick(); chk("top_pc", pc, 32'hFFFF_FFFC); chk("top_pcnext", pc_next, 32'h0);
      pc_sel = 2'b00;
      tick(); chk("wrap_pc", pc, 32'h0);
      en = 1'b0; trap_req = 1'b1;
      #1 chk("stall_fv", {31'b0, fetch_valid}, 32'h0);
      tick(); chk("stall_trap", pc, 32'h100);
      trap_req = 1'b0;
      tick(); chk("stall_hold", pc, 32'h100);

      // Trap during HOLD overwrites the pending sequential target.
      en = 1'b1; fetch_ready = 1'b0;
      tick(); chk("hold_t_addr", fetch_addr, 32'h100);
      trap_req = 1'b1;
      tick(); chk("hold_t_addr2", fetch_addr, 32'h100);
      trap_req = 1'b0; fetch_ready = 1'b1;
      tick(); chk("hold_t_pc", pc, 32'h100);

      // Reset asserted during HOLD with pending 0x40.
      pc_sel = `PC_MUX_PC_ADDER; pc_adder_result = 32'h40; fetch_ready = 1'b0;
      tick(); chk("pre_rst_fv", {31'b0, fetch_valid}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("hold_rst_pc", pc, 32'h0);
      chk("hold_rst_fv", {31'b0, fetch_valid}, 32'h0);
      #3;
      rst_n = 1'b1; pc_sel = 2'b00; fetch_ready = 1'b1;
      tick(); chk("post_rst_addr", fetch_addr, 32'h0);
      chk("post_rst_fv", {31'b0, fetch_valid}, 32'h1);
      tick(); chk("post_rst_seq", fetch_addr, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
